// File: rtl/mem_stall_controller_pkg.sv
// Shared definitions for the MEM-stage data-memory stall controller:
// FSM state encoding and default bus widths.
package mem_stall_controller_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int ADDR_W_DEF      = 16;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // An EX/MEM instruction needs the data memory if it reads or writes.
    function automatic logic is_access(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_stall_controller_if.sv
// Data-memory request/response bus between the stall controller (master)
// and the variable-latency data memory (slave).
interface mem_stall_controller_if
    import mem_stall_controller_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    // Handshake: the master raises dmem_req_valid with we/addr/wdata and holds
    // all of them stable until the cycle it samples dmem_req_ready high; that
    // cycle is the single transfer. dmem_rsp_valid is a one-cycle pulse (read
    // data or write ack) that the master only honours while waiting for it.
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic              dmem_req_we;
    logic [ADDR_W-1:0] dmem_req_addr;
    logic [DATA_W-1:0] dmem_req_wdata;
    logic              dmem_rsp_valid;
    logic [DATA_W-1:0] dmem_rsp_data;

    modport master (
        output dmem_req_valid,
        output dmem_req_we,
        output dmem_req_addr,
        output dmem_req_wdata,
        input  dmem_req_ready,
        input  dmem_rsp_valid,
        input  dmem_rsp_data
    );

    modport slave (
        input  dmem_req_valid,
        input  dmem_req_we,
        input  dmem_req_addr,
        input  dmem_req_wdata,
        output dmem_req_ready,
        output dmem_rsp_valid,
        output dmem_rsp_data
    );

endinterface

// File: rtl/mem_stall_controller_timeout.sv
// Saturating cycle counter used to abandon a data-memory access that never
// answers; expired is high once the count sits at TIMEOUT_CYC-1.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a stuck enable can never wrap back to a young count.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_stall_controller.sv
// MEM-stage data-memory access controller: issues one valid/ready request per
// load/store, freezes the pipeline until it completes, returns load data.
module mem_stall_controller
    import mem_stall_controller_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    mem_stall_controller_if.master dmem,
    output logic                   pipe_stall,
    output logic [DATA_W-1:0]      rdata,
    output logic                   access_err,
    output state_t                 dbg_state
);

    state_t            state;
    state_t            state_nxt;

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              capture;
    logic              accept;
    logic              rsp_take;
    logic              tmo_hit;
    logic              expired;

    mem_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .arst_n  (arst_n),
        .clear   (accept),
        .enable  (state == ST_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pipe_stall is combinational in IDLE so the access instruction is frozen
    // in EX/MEM on its very first MEM cycle; DONE releases it for one cycle.
    always_comb begin
        state_nxt  = state;
        pipe_stall = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        rsp_take   = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_access(mem_read, mem_write)) begin
                    pipe_stall = 1'b1;
                    capture    = 1'b1;
                    state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                pipe_stall = 1'b1;
                if (dmem.dmem_req_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pipe_stall = 1'b1;
                if (dmem.dmem_rsp_valid) begin
                    rsp_take  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields are latched once in IDLE and held until the next access,
    // so they cannot move while valid waits for ready. Read wins over write.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (capture) begin
            req_valid <= 1'b1;
            req_we    <= mem_write & ~mem_read;
            req_addr  <= addr;
            req_wdata <= wdata;
        end else if (accept) begin
            req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rdata      <= '0;
            access_err <= 1'b0;
        end else if (rsp_take) begin
            if (!req_we) begin
                rdata <= dmem.dmem_rsp_data;
            end
        end else if (tmo_hit) begin
            rdata      <= '0;
            access_err <= 1'b1;
        end
    end

    assign dmem.dmem_req_valid = req_valid;
    assign dmem.dmem_req_we    = req_we;
    assign dmem.dmem_req_addr  = req_addr;
    assign dmem.dmem_req_wdata = req_wdata;
    assign dbg_state           = state;

endmodule

// File: tb/tb_mem_stall_controller.sv
// Directed bench for mem_stall_controller: each access is described by its
// memory latencies and the expected per-cycle outputs are derived from them.
module tb_mem_stall_controller;
    import mem_stall_controller_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int TMO = 8;

    logic          clk       = 1'b0;
    logic          arst_n    = 1'b0;
    logic          mem_read  = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] addr      = '0;
    logic [DW-1:0] wdata     = '0;
    logic          pipe_stall;
    logic [DW-1:0] rdata;
    logic          access_err;
    state_t        dbg_state;

    mem_stall_controller_if #(.DATA_W(DW), .ADDR_W(AW)) dmem ();

    always #5 clk = ~clk;

    mem_stall_controller #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .dmem       (dmem.master),
        .pipe_stall (pipe_stall),
        .rdata      (rdata),
        .access_err (access_err),
        .dbg_state  (dbg_state)
    );

    typedef struct packed {
        logic          stall;
        logic          valid;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks   = 0;
    int            n_pass     = 0;
    int            stall_seen = 0;
    int            hs_seen    = 0;
    logic [DW-1:0] m_rdata    = '0;
    logic          m_err      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Scoreboard: one expectation per driven cycle, compared after outputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pipe_stall", pipe_stall, e.stall);
                check("req_valid", dmem.dmem_req_valid, e.valid);
                if (e.valid) begin
                    check("req_we", dmem.dmem_req_we, e.we);
                    check("req_addr", dmem.dmem_req_addr, e.a);
                    check("req_wdata", dmem.dmem_req_wdata, e.wd);
                end
                check("rdata", rdata, e.rd);
                check("access_err", access_err, e.err);
            end
            if (pipe_stall) stall_seen++;
            if (dmem.dmem_req_valid && dmem.dmem_req_ready) hs_seen++;
        end
    end

    task automatic idle_cycle(input logic spur, input logic [DW-1:0] spur_data);
        exp_t e;
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = spur;
        dmem.dmem_rsp_data  = spur_data;
        e = '0;
        e.rd  = m_rdata;
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    // One access: 1 IDLE cycle, ready_lat+1 REQ cycles, a WAIT phase of rsp_lat
    // cycles (rsp_lat=0: no response, TMO cycles), then one DONE cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input int ready_lat, input int rsp_lat,
                              input logic [DW-1:0] rsp_d, input logic spur_acc);
        int   n_req;
        int   n_wait;
        int   n_tot;
        logic exp_we;
        exp_t e;
        n_req  = ready_lat + 1;
        n_wait = (rsp_lat > 0) ? rsp_lat : TMO;
        n_tot  = 1 + n_req + n_wait + 1;
        exp_we = wr & ~rd;
        for (int k = 0; k < n_tot; k++) begin
            @(negedge clk);
            mem_read  = rd;
            mem_write = wr;
            addr      = a;
            wdata     = wd;
            dmem.dmem_req_ready = (k == n_req);
            dmem.dmem_rsp_valid = ((rsp_lat > 0) && (k == n_req + rsp_lat)) || (spur_acc && (k == n_req));
            dmem.dmem_rsp_data  = (k == n_req) ? ~rsp_d : rsp_d;
            if (k == n_tot - 1) begin
                if (rsp_lat == 0) begin
                    m_rdata = '0;
                    m_err   = 1'b1;
                end else if (!exp_we) begin
                    m_rdata = rsp_d;
                end
            end
            e.stall = (k < n_tot - 1);
            e.valid = (k >= 1) && (k <= n_req);
            e.we    = exp_we;
            e.a     = a;
            e.wd    = wd;
            e.rd    = m_rdata;
            e.err   = m_err;
            exp_q.push_back(e);
        end
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b0;
        dmem.dmem_rsp_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_valid", dmem.dmem_req_valid, 1'b0);
        check("reset_addr", dmem.dmem_req_addr, 16'h0000);
        check("reset_rdata", rdata, 16'h0000);
        check("reset_err", access_err, 1'b0);
        check("reset_stall", pipe_stall, 1'b0);
        check("reset_state", dbg_state, ST_IDLE);
        @(negedge clk);
        arst_n = 1'b1;
        idle_cycle(1'b0, '0);
        idle_cycle(1'b0, '0);

        stall_seen = 0;
        run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 1'b0);
        check("load_stall_cycles", stall_seen, 3);
        check("load_rdata", rdata, 16'hBEEF);
        check("load_req_once", hs_seen, 1);
        check("load_done_state", dbg_state, ST_DONE);

        idle_cycle(1'b1, 16'h5555);
        idle_cycle(1'b0, '0);

        stall_seen = 0;
        run_access(1'b0, 1'b1, 16'h0040, 16'h1234, 3, 1, 16'hDEAD, 1'b0);
        check("store_stall_cycles", stall_seen, 6);
        check("store_rdata_kept", rdata, 16'hBEEF);

        run_access(1'b1, 1'b1, 16'h0082, 16'hFFFF, 0, 2, 16'h0A0A, 1'b1);
        check("rw_spur_rdata", rdata, 16'h0A0A);

        stall_seen = 0;
        run_access(1'b1, 1'b0, 16'h00F0, 16'h0000, 0, 0, 16'h7777, 1'b0);
        check("tmo_stall_cycles", stall_seen, 10);
        check("tmo_rdata", rdata, 16'h0000);
        check("tmo_err", access_err, 1'b1);

        run_access(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 3, 16'h1111, 1'b0);
        run_access(1'b1, 1'b0, 16'h0102, 16'h0000, 0, 1, 16'h2222, 1'b0);
        check("b2b_rdata", rdata, 16'h2222);
        check("err_sticky", access_err, 1'b1);

        // Abort an access from WAIT with an asynchronous reset.
        @(negedge clk);
        mem_read = 1'b1;
        addr     = 16'h0200;
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b0;
        @(negedge clk);
        dmem.dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem.dmem_req_ready = 1'b0;
        #1;
        check("abort_pre_state", dbg_state, ST_WAIT);
        check("abort_pre_stall", pipe_stall, 1'b1);
        #1;
        arst_n   = 1'b0;
        mem_read = 1'b0;
        #1;
        check("abort_valid", dmem.dmem_req_valid, 1'b0);
        check("abort_addr", dmem.dmem_req_addr, 16'h0000);
        check("abort_rdata", rdata, 16'h0000);
        check("abort_err", access_err, 1'b0);
        check("abort_stall", pipe_stall, 1'b0);
        check("abort_state", dbg_state, ST_IDLE);
        m_rdata = '0;
        m_err   = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        idle_cycle(1'b0, '0);
        idle_cycle(1'b0, '0);
        #3;
        check("post_reset_state", dbg_state, ST_IDLE);
        check("total_handshakes", hs_seen, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
